counter_updown_mod: RTL

//  Parametrised next-generation counter. Supports up/down counting, a programmable modulus, wrap or saturate

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_prescaler.sv | 56 +++++
 rtl/counter_updown_mod.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Purpose: shared constants and helpers for the up/down counter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Limit a requested value to the top of the counting range.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Purpose: divides enabled cycles so the counter steps once every PRESCALE enabled cycles.
// Latency: tick is combinational from enable and the registered phase.
// Backpressure: none; enable low freezes the phase.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, active-low (phase -> 0)
//   enable   advances the phase by one per cycle
//   restart  forces the phase back to 0 (clear/load of the counter)
//   tick     high on the enabled cycle that completes a phase
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // Every enabled cycle is a step; no state is needed.
      assign tick = enable;
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset_n, restart};
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] ONE  = PW'(1);

      logic [PW-1:0] phase_q, phase_d;

      assign tick = enable && (phase_q == LAST);

      always_comb begin
        phase_d = phase_q;
        if (restart) begin
          phase_d = '0;
        end else if (tick) begin
          phase_d = '0;
        end else if (enable) begin
          phase_d = phase_q + ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// Purpose: up/down modulo counter with wrap/saturate, prescaler, load/clear and boundary flags.
// Latency: count updates on the qualifying edge; tc is combinational from count and up_dn.
// Backpressure: none; enable low holds count and prescaler phase.
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   enable, clear, load    step enable, sync clear, sync load (clear > load > step)
//   load_value, up_dn      load data (clamped to MAX_VALUE), direction (1 = up)
//   ovf_clr                clears ovf_sticky (a same-edge boundary event wins)
//   count, tc              registered count, terminal-count compare
//   wrap_pulse, ovf_sticky one-cycle boundary pulse, sticky boundary flag
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] MAX_VALUE = 32'h0000_FFFF,
  parameter bit          SATURATE  = 1'b0,
  parameter int          PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX_W = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .restart (clear | load),
    .tick    (step)
  );

  assign load_clamped = WIDTH'(clamp_to_max(32'(load_value), MAX_VALUE));

  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        // Compare against MAX_W rather than relying on native rollover,
        // so reduced moduli wrap at the right place.
        if (count_q == MAX_W) begin
          boundary = 1'b1;
          count_d  = SATURATE ? count_q : '0;
        end else begin
          count_d = count_q + ONE_W;
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = SATURATE ? count_q : MAX_W;
        end else begin
          count_d = count_q - ONE_W;
        end
      end
    end
    wrap_d = boundary;
    // A boundary event on the same edge as ovf_clr keeps the flag set.
    ovf_d  = boundary ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
  assign tc         = (up_dn == DIR_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule
